multicycle_main_controller: RTL
===============================

// Module: multicycle_main_controller
// PURPOSE
//   Moore FSM main controller for the multi-cycle RV32I core; successor to the single-cycle decode table.
//   Sequences FETCH/DECODE/EXEC/MEM/WB per instruction over a shared memory port with a ready handshake.
//   Sits between the instruction register (opCode) and the datapath muxes, ALU control and register file.
// PARAMETERS
//   OPCODE_W     7   opcode field width
//   ALUOP_W      2   ALUOp width to ALU control (00 add, 01 branch-cmp, 10 R-funct, 11 I-funct)
//   TIMEOUT_W    8   width of memory-wait counter
//   MEM_TIMEOUT  64  max wait cycles on mem_ready; 0 = wait forever
// PORTS
//   clk            in   1          clock, rising edge
//   reset          in   1          asynchronous, active-high
//   opCode         in   OPCODE_W   opcode of instruction register, valid from DECODE onward
//   mem_ready      in   1          memory completes the current read/write this cycle
//   pcWrite        out  1          load PC
//   irWrite        out  1          load instruction register
//   iorD           out  1          mem address: 0 PC, 1 ALUOut
//   memRead        out  1          memory read request
//   memWrite       out  1          memory write request
//   regWrite       out  1          register-file write enable
//   memToReg       out  1          writeback select: 0 ALUOut, 1 MDR
//   ALUSrcA        out  2          00 PC, 01 oldPC, 10 rs1
//   ALUSrcB        out  2          00 rs2, 01 const 4, 10 imm
//   ALUOp          out  ALUOP_W    to ALU control
//   branch         out  1          conditional PC update enable
//   jal, jalr      out  1          jump PC-select; writeback of PC+4
//   instr_done     out  1          1-cycle pulse on the cycle the FSM returns to FETCH
//   mem_timeout    out  1          1-cycle pulse when a memory wait is abandoned
//   state          out  4          current state (debug)
// BEHAVIOUR
//   - Reset: state=FETCH, wait counter=0, instr_done=mem_timeout=0; outputs decode FETCH immediately.
//   - All control outputs are a pure function of state (Moore); unlisted outputs are 0 in every state.
//   - FETCH(0): memRead, ALUSrcA=00, ALUSrcB=01, ALUOp=00; irWrite,pcWrite only while mem_ready; mem_ready->DECODE.
//   - DECODE(1): ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next by opCode: 0110011 EXEC_R; 0010011 EXEC_I;
//     0000011/0100011 MEM_ADDR; 1100011 BRANCH; 1101111 JAL; 1100111 JALR; other: see CONFIGURATION.
//   - MEM_ADDR(2): ALUSrcA=10, ALUSrcB=10, ALUOp=00; ->MEM_READ if load else MEM_WRITE.
//   - MEM_READ(3): memRead, iorD; mem_ready->MEM_WB.   MEM_WB(4): regWrite, memToReg; ->FETCH.
//   - MEM_WRITE(5): memWrite, iorD; mem_ready->FETCH.
//   - EXEC_R(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10; ->ALU_WB. EXEC_I(7): ALUSrcA=10, ALUSrcB=10, ALUOp=11; ->ALU_WB.
//   - ALU_WB(8): regWrite; ->FETCH.   BRANCH(9): branch, ALUSrcA=10, ALUSrcB=00, ALUOp=01; ->FETCH.
//   - JAL(10): jal, regWrite, pcWrite; ->FETCH.  JALR(11): jalr, regWrite, pcWrite, ALUSrcA=10, ALUSrcB=10; ->FETCH.
//   - Latency (zero-wait memory): R/I/branch/jump 3-4 cycles, load 5, store 4.
//   - Wait states = FETCH, MEM_READ, MEM_WRITE. Counter clears on entry and on mem_ready; increments each
//     cycle mem_ready=0. MEM_TIMEOUT!=0 and count==MEM_TIMEOUT-1 with mem_ready=0: pulse mem_timeout, ->FETCH,
//     no irWrite/pcWrite/regWrite issued for abandoned access. Counter saturates, never wraps.
//   - mem_ready and timeout same cycle: mem_ready wins. mem_ready outside wait states ignored.
//   - instr_done registered: high the cycle after the transition into FETCH (not on timeout, not after reset).
//   - Reset mid-instruction: immediate FETCH; no write strobe may glitch high on reset assertion.
// CONFIGURATION
//   MCC_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE -> TRAP(12); TRAP holds all strobes 0, output
//     illegal_instr (1 bit) sticky high until reset; state stays TRAP until reset.
//   Undefined: unknown opcode -> FETCH as NOP (instr_done pulses); no illegal_instr port; TRAP absent.
// TESTING
//   - reset high mid-MEM_READ -> state=0, memRead=1, iorD=0, regWrite=0 same cycle (async).
//   - opCode=0110011, mem_ready=1 always -> states 0,1,6,8,0; regWrite in cycle 4; instr_done cycle 5.
//   - lw, mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with memToReg=1.
//   - MEM_TIMEOUT=4, sw with mem_ready=0 -> 4 cycles MEM_WRITE, mem_timeout pulse, ->FETCH, no instr_done.
//   - opCode=1101111 -> JAL: jal=pcWrite=regWrite=1 one cycle; opCode=1100011 -> branch=1, ALUOp=01.
//   - opCode=0000000: with MCC_ILLEGAL_TRAP_EN -> TRAP, illegal_instr=1 held; without -> FETCH, instr_done=1.

Source files
------------

// File: rtl/multicycle_main_controller_if.sv
// rtl/multicycle_main_controller_if.sv - shared memory port between main controller and memory
//
// Signals:
//   mem_ready  memory completes the current read/write this cycle (memory -> controller)
//   memRead    read request (controller -> memory)
//   memWrite   write request (controller -> memory)
//   iorD       address select: 0 PC, 1 ALUOut (controller -> memory mux)
// Modports: master = controller side, slave = memory side.
interface multicycle_main_controller_if;
  logic mem_ready;
  logic memRead;
  logic memWrite;
  logic iorD;

  modport master (input mem_ready, output memRead, output memWrite, output iorD);
  modport slave  (output mem_ready, input memRead, input memWrite, input iorD);
endinterface

// File: rtl/multicycle_main_controller.sv
// rtl/multicycle_main_controller.sv - Moore FSM main controller for the multi-cycle RV32I core
//
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a ready handshake.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   opCode            instruction-register opcode, valid from DECODE onward
//   mem               memory port (mem_ready in; memRead, memWrite, iorD out)
//   pcWrite, irWrite  PC / IR load strobes
//   regWrite,memToReg register-file write enable and writeback select
//   ALUSrcA/B, ALUOp  ALU operand selects and ALU control class
//   branch, jal, jalr PC-select controls
//   instr_done        registered pulse the cycle after an instruction returns to FETCH
//   mem_timeout       registered pulse the cycle after a memory wait is abandoned
//   illegal_instr     sticky illegal-opcode flag (only with MCC_ILLEGAL_TRAP_EN)
//   state             current state (debug)
// Optional feature: define MCC_ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP state;
// otherwise unknown opcodes retire as a NOP.
module multicycle_main_controller #(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opCode,
  multicycle_main_controller_if.master mem,
  output logic                pcWrite,
  output logic                irWrite,
  output logic                regWrite,
  output logic                memToReg,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                branch,
  output logic                jal,
  output logic                jalr,
  output logic                instr_done,
  output logic                mem_timeout,
`ifdef MCC_ILLEGAL_TRAP_EN
  output logic                illegal_instr,
`endif
  output logic [3:0]          state
);

  localparam logic [OPCODE_W-1:0] OP_R     = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I     = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR    = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR  = OPCODE_W'(7'b1100111);

  // Last count value before a wait is abandoned; unused when MEM_TIMEOUT is 0.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11
`ifdef MCC_ILLEGAL_TRAP_EN
    , S_TRAP    = 4'd12
`endif
  } state_t;

  state_t                 cur_st, nxt_st;
  logic [TIMEOUT_W-1:0]   wait_cnt;
  logic                   wait_st;
  logic                   timeout_hit;

  assign state   = cur_st;
  assign wait_st = (cur_st == S_FETCH) || (cur_st == S_MEM_READ) || (cur_st == S_MEM_WRITE);
  // mem_ready has priority: a completing access is never abandoned.
  assign timeout_hit = (MEM_TIMEOUT != 0) && wait_st && !mem.mem_ready && (wait_cnt == TO_LAST);

`ifdef MCC_ILLEGAL_TRAP_EN
  // TRAP is only left through reset, so the state itself is the sticky flag.
  assign illegal_instr = (cur_st == S_TRAP);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st      <= S_FETCH;
      wait_cnt    <= '0;
      instr_done  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      cur_st      <= nxt_st;
      mem_timeout <= timeout_hit;
      instr_done  <= (nxt_st == S_FETCH) && (cur_st != S_FETCH) && !timeout_hit;
      // FETCH->FETCH on timeout keeps the state, so the abandon itself must clear too.
      if (!wait_st || mem.mem_ready || timeout_hit || (nxt_st != cur_st))
        wait_cnt <= '0;
      else if (wait_cnt != {TIMEOUT_W{1'b1}})
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt_st       = cur_st;
    pcWrite      = 1'b0;
    irWrite      = 1'b0;
    mem.iorD     = 1'b0;
    mem.memRead  = 1'b0;
    mem.memWrite = 1'b0;
    regWrite     = 1'b0;
    memToReg     = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = '0;
    branch       = 1'b0;
    jal          = 1'b0;
    jalr         = 1'b0;
    case (cur_st)
      S_FETCH: begin
        mem.memRead = 1'b1;
        ALUSrcB     = 2'b01;
        // Gated by reset so an asynchronous reset landing in FETCH cannot strobe PC/IR.
        if (mem.mem_ready && !reset) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
        end
        if (mem.mem_ready) nxt_st = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        case (opCode)
          OP_R:              nxt_st = S_EXEC_R;
          OP_I:              nxt_st = S_EXEC_I;
          OP_LOAD, OP_STORE: nxt_st = S_MEM_ADDR;
          OP_BR:             nxt_st = S_BRANCH;
          OP_JAL:            nxt_st = S_JAL;
          OP_JALR:           nxt_st = S_JALR;
`ifdef MCC_ILLEGAL_TRAP_EN
          default:           nxt_st = S_TRAP;
`else
          default:           nxt_st = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
        nxt_st  = (opCode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem.memRead = 1'b1;
        mem.iorD    = 1'b1;
        if (mem.mem_ready)  nxt_st = S_MEM_WB;
        else if (timeout_hit) nxt_st = S_FETCH;
      end
      S_MEM_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        nxt_st   = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem.memWrite = 1'b1;
        mem.iorD     = 1'b1;
        if (mem.mem_ready || timeout_hit) nxt_st = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = ALUOP_W'(2'b10);
        nxt_st  = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
        ALUOp   = ALUOP_W'(2'b11);
        nxt_st  = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite = 1'b1;
        nxt_st   = S_FETCH;
      end
      S_BRANCH: begin
        branch  = 1'b1;
        ALUSrcA = 2'b10;
        ALUOp   = ALUOP_W'(2'b01);
        nxt_st  = S_FETCH;
      end
      S_JAL: begin
        jal      = 1'b1;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        nxt_st   = S_FETCH;
      end
      S_JALR: begin
        jalr     = 1'b1;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b10;
        nxt_st   = S_FETCH;
      end
`ifdef MCC_ILLEGAL_TRAP_EN
      S_TRAP: nxt_st = S_TRAP;
`endif
      default: nxt_st = S_FETCH;
    endcase
  end

endmodule
